// File: rtl/lcd_pio_sequencer.sv
// HD44780 LCD sequencer: power-up init from a fixed ROM, then one timed bus
// write per toggle-framed PIO command word.
module lcd_pio_sequencer #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 12,
  parameter int T_SHORT   = 2000,
  parameter int T_LONG    = 82000,
  parameter int CNT_W     = 20
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] lcd_cmd,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        busy,
  output logic        init_done,
  output logic        ack_toggle
);

  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, limit;
  logic             cnt_done;
  logic [2:0]       init_idx;
  logic             long_wait;
  logic             last_toggle;
  logic             accept;
  logic             unused_cmd_bits;

  assign unused_cmd_bits = ^lcd_cmd[30:11];

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      default:          init_rom = 8'h06;
    endcase
  endfunction

  // Each timed state holds for limit+1 cycles, counted from cnt=0 on entry.
  always_comb begin
    limit = '0;
    case (state)
      PWRUP:   limit = CNT_W'(T_POWERUP - 1);
      SETUP:   limit = CNT_W'(T_SETUP - 1);
      PULSE:   limit = CNT_W'(T_EN - 1);
      WAIT:    limit = long_wait ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);
      default: limit = '0;
    endcase
  end

  assign cnt_done = (cnt == limit);
  assign accept   = (state == IDLE) && (lcd_cmd[31] != last_toggle);

  always_comb begin
    state_next = state;
    case (state)
      PWRUP:   if (cnt_done) state_next = SETUP;
      SETUP:   if (cnt_done) state_next = PULSE;
      PULSE:   if (cnt_done) state_next = HOLD;
      HOLD:    state_next = WAIT;
      WAIT:    if (cnt_done)
                 state_next = (!init_done && init_idx != 3'd5) ? SETUP : IDLE;
      IDLE:    if (accept) state_next = SETUP;
      default: state_next = PWRUP;
    endcase
  end

  assign lcd_en = (state == PULSE);
  assign busy   = (state != IDLE);
  assign lcd_rw = 1'b0;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state       <= PWRUP;
      cnt         <= '0;
      init_idx    <= '0;
      long_wait   <= 1'b0;
      last_toggle <= 1'b0;
      lcd_data    <= '0;
      lcd_rs      <= 1'b0;
      lcd_on      <= 1'b0;
      lcd_blon    <= 1'b0;
      init_done   <= 1'b0;
      ack_toggle  <= 1'b0;
    end else begin
      state    <= state_next;
      lcd_on   <= 1'b1;
      lcd_blon <= lcd_cmd[10];
      if (state_next != state || state == IDLE || state == HOLD)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      case (state)
        PWRUP: if (cnt_done) begin
          lcd_data  <= init_rom(3'd0);
          lcd_rs    <= 1'b0;
          long_wait <= 1'b1;
          init_idx  <= '0;
        end
        WAIT: if (cnt_done) begin
          if (!init_done && init_idx != 3'd5) begin
            init_idx <= init_idx + 3'd1;
            lcd_data <= init_rom(init_idx + 3'd1);
          end else begin
            if (!init_done) init_done <= 1'b1;
            ack_toggle <= last_toggle;
          end
        end
        // Bits latched here are frozen until the next acceptance.
        IDLE: if (accept) begin
          lcd_data    <= lcd_cmd[7:0];
          lcd_rs      <= lcd_cmd[8];
          long_wait   <= lcd_cmd[9];
          last_toggle <= lcd_cmd[31];
        end
        default: ;
      endcase
    end
  end

endmodule
